// File: rtl/fall_rank_recorder.sv
// fall_rank_recorder
//   Records the order and time at which up to N_CH channels fall inside an
//   armed window, builds a k-nearest mask from the arrival ranks, then streams
//   one result entry per channel to a downstream consumer.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   i_start         arm a new window (only honoured while idle)
//   i_k             k select, effective k = i_k + 1, sampled with i_start
//   i_fall          one-cycle falling-edge pulses, bit i = channel i
//   o_busy          high whenever the recorder is not idle
//   o_knn_mask      bit i set when channel i arrived with rank < k
//   o_timeout       window closed by timer saturation (sticky until next start)
//   o_rank_valid    result entry valid (drain phase only)
//   i_rank_ready    consumer ready for the current entry
//   o_rank_ch       channel index of the current entry
//   o_rank_hit      channel fell inside the window
//   o_rank_idx      arrival rank of the channel (0 when not hit)
//   o_rank_time     timer value at the fall (0 when not hit)
//   o_done          one-cycle pulse after the final entry is accepted
//   o_dbg_state     current FSM state (0 idle, 1 armed, 2 drain)
//
// Result stream handshake: an entry transfers on every rising edge where
// o_rank_valid and i_rank_ready are both high. While valid is high and ready
// is low, every entry field holds steady; valid never drops without a transfer.
module fall_rank_recorder #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 12,
  parameter int K_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [K_W-1:0]           i_k,
  input  logic [N_CH-1:0]          i_fall,
  output logic                     o_busy,
  output logic [N_CH-1:0]          o_knn_mask,
  output logic                     o_timeout,
  output logic                     o_rank_valid,
  input  logic                     i_rank_ready,
  output logic [$clog2(N_CH)-1:0]  o_rank_ch,
  output logic                     o_rank_hit,
  output logic [$clog2(N_CH)-1:0]  o_rank_idx,
  output logic [CNT_W-1:0]         o_rank_time,
  output logic                     o_done,
  output logic [1:0]               o_dbg_state
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int PC_W  = $clog2(N_CH + 1);
  localparam int KC_W  = K_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [N_CH-1:0]    seen_q, seen_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic               timeout_q, timeout_d;
  logic [KC_W-1:0]    k_q, k_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   rank_q [N_CH];
  logic [IDX_W-1:0]   rank_d [N_CH];
  logic [CNT_W-1:0]   time_q [N_CH];
  logic [CNT_W-1:0]   time_d [N_CH];

  logic [N_CH-1:0]    new_fall;
  logic [IDX_W-1:0]   rank_new [N_CH];
  logic [PC_W-1:0]    run_cnt;

  function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Ranks for this cycle's new falls: channels already seen come first, then
  // simultaneous newcomers in ascending channel order.
  always_comb begin
    new_fall = '0;
    if (state_q == ST_ARMED) new_fall = i_fall & ~seen_q;
    run_cnt = popcount(seen_q);
    for (int i = 0; i < N_CH; i++) begin
      rank_new[i] = run_cnt[IDX_W-1:0];
      if (new_fall[i]) run_cnt = run_cnt + PC_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    seen_d    = seen_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    k_d       = k_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    rank_d    = rank_q;
    time_d    = time_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_ARMED;
          timer_d   = '0;
          seen_d    = '0;
          mask_d    = '0;
          timeout_d = 1'b0;
          k_d       = KC_W'(i_k) + KC_W'(1);
          ptr_d     = '0;
          for (int i = 0; i < N_CH; i++) begin
            rank_d[i] = '0;
            time_d[i] = '0;
          end
        end
      end

      ST_ARMED: begin
        // Timer saturates instead of wrapping; reaching max closes the window.
        if (timer_q != '1) timer_d = timer_q + CNT_W'(1);
        seen_d = seen_q | new_fall;
        for (int i = 0; i < N_CH; i++) begin
          if (new_fall[i]) begin
            rank_d[i] = rank_new[i];
            time_d[i] = timer_q;
            mask_d[i] = (KC_W'(rank_new[i]) < k_q);
          end
        end
        ptr_d = '0;
        if (timer_q == '1) begin
          state_d   = ST_DRAIN;
          timeout_d = 1'b1;
        end else if (&(seen_q | new_fall)) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (i_rank_ready) begin
          if (ptr_q == IDX_W'(N_CH - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      seen_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
      k_q       <= '0;
      ptr_q     <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        rank_q[i] <= '0;
        time_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      seen_q    <= seen_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      k_q       <= k_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      rank_q    <= rank_d;
      time_q    <= time_d;
    end
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_knn_mask   = mask_q;
  assign o_timeout    = timeout_q;
  assign o_rank_valid = (state_q == ST_DRAIN);
  assign o_rank_ch    = o_rank_valid ? ptr_q : '0;
  assign o_rank_hit   = o_rank_valid & seen_q[ptr_q];
  assign o_rank_idx   = o_rank_hit ? rank_q[ptr_q] : '0;
  assign o_rank_time  = o_rank_hit ? time_q[ptr_q] : '0;
  assign o_done       = done_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_fall_rank_recorder.sv
module tb_fall_rank_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_k = 3'd0;
  logic [7:0]  i_fall = 8'h00;
  logic        i_rank_ready = 1'b0;
  logic        o_busy;
  logic [7:0]  o_knn_mask;
  logic        o_timeout;
  logic        o_rank_valid;
  logic [2:0]  o_rank_ch;
  logic        o_rank_hit;
  logic [2:0]  o_rank_idx;
  logic [11:0] o_rank_time;
  logic        o_done;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cur_t    = 0;

  logic        exp_hit  [8];
  logic [2:0]  exp_rank [8];
  logic [11:0] exp_time [8];

  fall_rank_recorder dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_k          (i_k),
    .i_fall       (i_fall),
    .o_busy       (o_busy),
    .o_knn_mask   (o_knn_mask),
    .o_timeout    (o_timeout),
    .o_rank_valid (o_rank_valid),
    .i_rank_ready (i_rank_ready),
    .o_rank_ch    (o_rank_ch),
    .o_rank_hit   (o_rank_hit),
    .o_rank_idx   (o_rank_idx),
    .o_rank_time  (o_rank_time),
    .o_done       (o_done),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic start_window(input logic [2:0] k);
    i_start = 1'b1;
    i_k     = k;
    tick();
    i_start = 1'b0;
    cur_t   = 0;
  endtask

  task automatic fall_at(input int t, input logic [7:0] m);
    while (cur_t < t) begin
      tick();
      cur_t++;
    end
    i_fall = m;
    tick();
    i_fall = 8'h00;
    cur_t++;
  endtask

  task automatic set_exp(input int ch, input logic hit, input logic [2:0] rank, input logic [11:0] t);
    exp_hit[ch]  = hit;
    exp_rank[ch] = rank;
    exp_time[ch] = t;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) set_exp(i, 1'b0, 3'd0, 12'd0);
  endtask

  // Drains the stream, stalling i_rank_ready low for stall_len cycles when
  // entry stall_at is presented, and checks every presented entry.
  task automatic drain(input int stall_at, input int stall_len);
    int p = 0;
    int stalled = 0;
    int guard = 0;
    logic [20:0] got, want;
    while (p < 8 && guard < 100) begin
      if (stall_len > 0 && p == stall_at && stalled < stall_len) begin
        i_rank_ready = 1'b0;
        stalled++;
      end else begin
        i_rank_ready = 1'b1;
      end
      got  = {o_rank_valid, o_rank_ch, o_rank_hit, o_rank_idx, o_rank_time, o_done};
      want = {1'b1, 3'(p), exp_hit[p], exp_rank[p], exp_time[p], 1'b0};
      if (got !== want)
        $display("FAIL drain_entry p=%0d: got %h expected %h", p, got, want);
      else n_pass++;
      n_checks++;
      if (i_rank_ready) p++;
      tick();
      guard++;
    end
    i_rank_ready = 1'b0;
    if (guard >= 100) $display("FAIL drain_budget: got %0d entries expected 8", p);
    else n_pass++;
    n_checks++;
    if ({o_done, o_rank_valid, o_busy} !== 3'b100)
      $display("FAIL done_pulse: got %b expected 100", {o_done, o_rank_valid, o_busy});
    else n_pass++;
    n_checks++;
    tick();
    if ({o_done, o_rank_valid, o_busy} !== 3'b000)
      $display("FAIL done_clear: got %b expected 000", {o_done, o_rank_valid, o_busy});
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if ({o_busy, o_knn_mask, o_timeout, o_rank_valid, o_done, o_dbg_state} !== 14'd0)
      $display("FAIL reset_ctrl: got %h expected 0",
               {o_busy, o_knn_mask, o_timeout, o_rank_valid, o_done, o_dbg_state});
    else n_pass++;
    n_checks++;
    if ({o_rank_ch, o_rank_hit, o_rank_idx, o_rank_time} !== 19'd0)
      $display("FAIL reset_data: got %h expected 0", {o_rank_ch, o_rank_hit, o_rank_idx, o_rank_time});
    else n_pass++;
    n_checks++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_order();
    start_window(3'd1);
    if ({o_busy, o_dbg_state, o_knn_mask} !== {1'b1, 2'd1, 8'h00})
      $display("FAIL basic_armed: got %h expected %h", {o_busy, o_dbg_state, o_knn_mask}, {1'b1, 2'd1, 8'h00});
    else n_pass++;
    n_checks++;
    fall_at(5, 8'h08);
    if (o_knn_mask !== 8'h08) $display("FAIL basic_mask_early: got %h expected 08", o_knn_mask);
    else n_pass++;
    n_checks++;
    fall_at(9, 8'h01);
    fall_at(20, 8'hF6);
    if ({o_dbg_state, o_knn_mask, o_timeout} !== {2'd2, 8'h09, 1'b0})
      $display("FAIL basic_drain_entry: got %h expected %h", {o_dbg_state, o_knn_mask, o_timeout}, {2'd2, 8'h09, 1'b0});
    else n_pass++;
    n_checks++;
    set_exp(0, 1'b1, 3'd1, 12'd9);
    set_exp(1, 1'b1, 3'd2, 12'd20);
    set_exp(2, 1'b1, 3'd3, 12'd20);
    set_exp(3, 1'b1, 3'd0, 12'd5);
    set_exp(4, 1'b1, 3'd4, 12'd20);
    set_exp(5, 1'b1, 3'd5, 12'd20);
    set_exp(6, 1'b1, 3'd6, 12'd20);
    set_exp(7, 1'b1, 3'd7, 12'd20);
    drain(0, 0);
  endtask

  task automatic test_timeout();
    int n = 0;
    start_window(3'd0);
    fall_at(3, 8'h24);
    while (!o_rank_valid && n < 5000) begin
      tick();
      n++;
    end
    if (n !== 4092) $display("FAIL timeout_cycles: got %0d expected 4092", n);
    else n_pass++;
    n_checks++;
    if ({o_timeout, o_knn_mask} !== {1'b1, 8'h04})
      $display("FAIL timeout_flags: got %h expected %h", {o_timeout, o_knn_mask}, {1'b1, 8'h04});
    else n_pass++;
    n_checks++;
    clear_exp();
    set_exp(2, 1'b1, 3'd0, 12'd3);
    set_exp(5, 1'b1, 3'd1, 12'd3);
    drain(0, 0);
    if ({o_timeout, o_knn_mask} !== {1'b1, 8'h04})
      $display("FAIL timeout_sticky: got %h expected %h", {o_timeout, o_knn_mask}, {1'b1, 8'h04});
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_repeat_pulse();
    start_window(3'd7);
    if ({o_timeout, o_knn_mask} !== 9'd0)
      $display("FAIL repeat_start_clear: got %h expected 0", {o_timeout, o_knn_mask});
    else n_pass++;
    n_checks++;
    fall_at(2, 8'h10);
    fall_at(6, 8'h10);
    if ({o_dbg_state, o_knn_mask} !== {2'd1, 8'h10})
      $display("FAIL repeat_mask: got %h expected %h", {o_dbg_state, o_knn_mask}, {2'd1, 8'h10});
    else n_pass++;
    n_checks++;
    fall_at(8, 8'h01);
    fall_at(10, 8'hEE);
    if (o_knn_mask !== 8'hFF) $display("FAIL repeat_mask_full: got %h expected ff", o_knn_mask);
    else n_pass++;
    n_checks++;
    set_exp(0, 1'b1, 3'd1, 12'd8);
    set_exp(1, 1'b1, 3'd2, 12'd10);
    set_exp(2, 1'b1, 3'd3, 12'd10);
    set_exp(3, 1'b1, 3'd4, 12'd10);
    set_exp(4, 1'b1, 3'd0, 12'd2);
    set_exp(5, 1'b1, 3'd5, 12'd10);
    set_exp(6, 1'b1, 3'd6, 12'd10);
    set_exp(7, 1'b1, 3'd7, 12'd10);
    drain(0, 0);
  endtask

  task automatic test_back_to_back_stall();
    start_window(3'd3);
    fall_at(0, 8'hFF);
    if ({o_dbg_state, o_knn_mask} !== {2'd2, 8'h0F})
      $display("FAIL stall_drain_entry: got %h expected %h", {o_dbg_state, o_knn_mask}, {2'd2, 8'h0F});
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 8; i++) set_exp(i, 1'b1, 3'(i), 12'd0);
    drain(3, 5);
  endtask

  task automatic test_reset_mid_window();
    start_window(3'd2);
    fall_at(1, 8'h02);
    fall_at(2, 8'h40);
    fall_at(4, 8'h08);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if ({o_busy, o_knn_mask, o_timeout, o_rank_valid, o_done, o_dbg_state} !== 14'd0)
      $display("FAIL midreset_ctrl: got %h expected 0",
               {o_busy, o_knn_mask, o_timeout, o_rank_valid, o_done, o_dbg_state});
    else n_pass++;
    n_checks++;
    tick();
    tick();
    if ({o_done, o_busy} !== 2'b00) $display("FAIL midreset_no_done: got %b expected 00", {o_done, o_busy});
    else n_pass++;
    n_checks++;
    start_window(3'd2);
    fall_at(0, 8'h40);
    fall_at(2, 8'hBF);
    if (o_knn_mask !== 8'h43) $display("FAIL midreset_mask: got %h expected 43", o_knn_mask);
    else n_pass++;
    n_checks++;
    set_exp(0, 1'b1, 3'd1, 12'd2);
    set_exp(1, 1'b1, 3'd2, 12'd2);
    set_exp(2, 1'b1, 3'd3, 12'd2);
    set_exp(3, 1'b1, 3'd4, 12'd2);
    set_exp(4, 1'b1, 3'd5, 12'd2);
    set_exp(5, 1'b1, 3'd6, 12'd2);
    set_exp(6, 1'b1, 3'd0, 12'd0);
    set_exp(7, 1'b1, 3'd7, 12'd2);
    drain(0, 0);
  endtask

  task automatic test_ignored_inputs();
    start_window(3'd0);
    fall_at(0, 8'hFF);
    i_rank_ready = 1'b0;
    i_start = 1'b1;
    i_k     = 3'd7;
    tick();
    tick();
    i_start = 1'b0;
    if ({o_dbg_state, o_rank_valid, o_rank_ch, o_knn_mask} !== {2'd2, 1'b1, 3'd0, 8'h01})
      $display("FAIL ignore_start: got %h expected %h",
               {o_dbg_state, o_rank_valid, o_rank_ch, o_knn_mask}, {2'd2, 1'b1, 3'd0, 8'h01});
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 8; i++) set_exp(i, 1'b1, 3'(i), 12'd0);
    drain(0, 0);
    i_fall = 8'hFF;
    tick();
    tick();
    i_fall = 8'h00;
    if ({o_busy, o_dbg_state, o_knn_mask, o_timeout, o_rank_valid} !== {1'b0, 2'd0, 8'h01, 1'b0, 1'b0})
      $display("FAIL ignore_fall: got %h expected %h",
               {o_busy, o_dbg_state, o_knn_mask, o_timeout, o_rank_valid}, {1'b0, 2'd0, 8'h01, 1'b0, 1'b0});
    else n_pass++;
    n_checks++;
    start_window(3'd1);
    fall_at(0, 8'h20);
    if ({o_dbg_state, o_knn_mask} !== {2'd1, 8'h20})
      $display("FAIL ignore_fall_seen: got %h expected %h", {o_dbg_state, o_knn_mask}, {2'd1, 8'h20});
    else n_pass++;
    n_checks++;
  endtask

  initial begin
    clear_exp();
    test_reset();
    test_basic_order();
    test_timeout();
    test_repeat_pulse();
    test_back_to_back_stall();
    test_reset_mid_window();
    test_ignored_inputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
